// File: rtl/id_fwd_scoreboard.sv
// id_fwd_scoreboard
//
// Decode-stage operand forwarding and hazard unit used to resolve branches
// and jump-register instructions in ID. A shift-register scoreboard records
// the in-flight register writes, one entry per downstream pipeline register
// (position 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, ...). For every source operand
// read by the ID instruction the unit selects where the value comes from, or
// requests a stall when the youngest producer has not yet produced it.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   id_valid      ID holds a valid instruction
//   id_src_addr   NSRC packed source register addresses (source i at i*REGW)
//   id_src_used   per-source "operand is read in ID" flags
//   id_wr, id_rd  ID instruction writes register id_rd
//   id_lat        first pipeline-register position holding the result
//   hold          downstream freeze: scoreboard does not shift
//   flush         kill the ID instruction (never inserted, never stalls)
//   fwd_sel       per source: 0 = register file, p = pipeline register p
//   stall         hold PC/IF/ID and insert a bubble
//   stall_run     consecutive stall cycles, saturating
//   stall_total   total stall cycles not masked by hold, wrapping
module id_fwd_scoreboard #(
  parameter int NSRC  = 2,
  parameter int REGW  = 5,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH + 1),
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*REGW-1:0]   id_src_addr,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   id_wr,
  input  logic [REGW-1:0]        id_rd,
  input  logic [SELW-1:0]        id_lat,
  input  logic                   hold,
  input  logic                   flush,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [CW-1:0]          stall_run,
  output logic [31:0]            stall_total
);

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] rd;
    logic [SELW-1:0] lat;
  } entry_t;

  localparam logic [SELW-1:0] MaxLat = SELW'(DEPTH - 1);
  localparam logic [CW-1:0]   RunMax = {CW{1'b1}};

  entry_t          sbQ [DEPTH];
  logic [NSRC-1:0] hazard;
  logic [REGW-1:0] srcAddr;
  logic            matchFound;
  logic [SELW-1:0] matchPos;
  logic [SELW-1:0] matchLat;
  logic [SELW-1:0] latClamped;
  logic            insertEn;

  // Per-source lookup. Scanning from the oldest position down to 0 lets the
  // youngest match overwrite older ones, so an older forwardable copy never
  // hides a younger producer that is still in flight.
  always_comb begin
    fwd_sel    = '0;
    hazard     = '0;
    srcAddr    = '0;
    matchFound = 1'b0;
    matchPos   = '0;
    matchLat   = '0;
    for (int i = 0; i < NSRC; i++) begin
      srcAddr    = id_src_addr[i*REGW +: REGW];
      matchFound = 1'b0;
      matchPos   = '0;
      matchLat   = '0;
      for (int p = DEPTH - 1; p >= 0; p--) begin
        if (sbQ[p].v && (sbQ[p].rd == srcAddr)) begin
          matchFound = 1'b1;
          matchPos   = SELW'(p);
          matchLat   = sbQ[p].lat;
        end
      end
      // Register 0 is hard-wired, so it never forwards and never stalls.
      if (id_src_used[i] && (srcAddr != '0) && matchFound) begin
        if (matchPos >= matchLat) begin
          fwd_sel[i*SELW +: SELW] = matchPos;
        end else begin
          hazard[i] = 1'b1;
        end
      end
    end
  end

  // Deliberately not gated by hold: a frozen pipeline still must not let a
  // hazarded branch resolve.
  assign stall = id_valid & ~flush & (|hazard);

  // A latency of 0 would let position 0 forward a value that does not exist
  // yet, and anything beyond the last position could never be forwarded.
  always_comb begin
    if (id_lat == '0) begin
      latClamped = SELW'(1);
    end else if (id_lat > MaxLat) begin
      latClamped = MaxLat;
    end else begin
      latClamped = id_lat;
    end
  end

  assign insertEn = id_valid & id_wr & (id_rd != '0) & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < DEPTH; p++) begin
        sbQ[p] <= '0;
      end
      stall_run   <= '0;
      stall_total <= '0;
    end else begin
      if (!hold) begin
        // The oldest entry falls off the end: its value is in the register
        // file from this edge on.
        for (int p = 1; p < DEPTH; p++) begin
          sbQ[p] <= sbQ[p-1];
        end
        if (insertEn) begin
          sbQ[0] <= '{v: 1'b1, rd: id_rd, lat: latClamped};
        end else begin
          sbQ[0] <= '0;
        end
      end
      if (stall) begin
        stall_run <= (stall_run == RunMax) ? stall_run : stall_run + 1'b1;
      end else begin
        stall_run <= '0;
      end
      stall_total <= stall_total + {31'b0, stall & ~hold};
    end
  end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// tb_id_fwd_scoreboard
//
// Directed bench for id_fwd_scoreboard with the default geometry
// (NSRC = 2, REGW = 5, DEPTH = 3, SELW = 2, CW = 8). Each vector is one clock
// cycle: inputs are driven just after the falling edge and the outputs are
// sampled 1 ns later, so fwd_sel/stall reflect the current inputs and the
// counters reflect all earlier rising edges.
module tb_id_fwd_scoreboard;

  localparam int NSRC  = 2;
  localparam int REGW  = 5;
  localparam int DEPTH = 3;
  localparam int SELW  = 2;
  localparam int CW    = 8;
  localparam int W     = NSRC*SELW + 1 + CW + 32;

  logic                 clk;
  logic                 rst;
  logic                 id_valid;
  logic [NSRC*REGW-1:0] id_src_addr;
  logic [NSRC-1:0]      id_src_used;
  logic                 id_wr;
  logic [REGW-1:0]      id_rd;
  logic [SELW-1:0]      id_lat;
  logic                 hold;
  logic                 flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic [CW-1:0]        stall_run;
  logic [31:0]          stall_total;

  id_fwd_scoreboard #(
    .NSRC(NSRC), .REGW(REGW), .DEPTH(DEPTH), .SELW(SELW), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_src_addr(id_src_addr),
    .id_src_used(id_src_used),
    .id_wr(id_wr),
    .id_rd(id_rd),
    .id_lat(id_lat),
    .hold(hold),
    .flush(flush),
    .fwd_sel(fwd_sel),
    .stall(stall),
    .stall_run(stall_run),
    .stall_total(stall_total)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst         = 1'b1;
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_used = '0;
    id_wr       = 1'b0;
    id_rd       = '0;
    id_lat      = '0;
    hold        = 1'b0;
    flush       = 1'b0;
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic            rst;
    logic            hold;
    logic            flush;
    logic            valid;
    logic            wr;
    logic [4:0]      rd;
    logic [1:0]      lat;
    logic [4:0]      src0;
    logic [4:0]      src1;
    logic [1:0]      used;
    logic [3:0]      expFwd;
    logic            expStall;
    logic [7:0]      expRun;
    logic [31:0]     expTotal;
  } vec_t;

  function automatic vec_t mk(input int r, input int h, input int f, input int v,
                              input int w, input int rd, input int lat,
                              input int s0, input int s1, input int used,
                              input int eFwd, input int eStall, input int eRun,
                              input int eTotal);
    vec_t t;
    t.rst      = r[0];
    t.hold     = h[0];
    t.flush    = f[0];
    t.valid    = v[0];
    t.wr       = w[0];
    t.rd       = rd[4:0];
    t.lat      = lat[1:0];
    t.src0     = s0[4:0];
    t.src1     = s1[4:0];
    t.used     = used[1:0];
    t.expFwd   = eFwd[3:0];
    t.expStall = eStall[0];
    t.expRun   = eRun[7:0];
    t.expTotal = eTotal;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int nChecks = 0;
  int nFails  = 0;

  task automatic check_field(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s %s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic check_outputs(input string name);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      nFails++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    check_field(name, "fwd_sel",     32'(fwd_sel),     32'(e[W-1 -: NSRC*SELW]));
    check_field(name, "stall",       32'(stall),       32'(e[CW+32]));
    check_field(name, "stall_run",   32'(stall_run),   32'(e[CW+31:32]));
    check_field(name, "stall_total", stall_total,      e[31:0]);
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    rst         = v.rst;
    hold        = v.hold;
    flush       = v.flush;
    id_valid    = v.valid;
    id_wr       = v.wr;
    id_rd       = v.rd;
    id_lat      = v.lat;
    id_src_addr = {v.src1, v.src0};
    id_src_used = v.used;
    exp_q.push_back({v.expFwd, v.expStall, v.expRun, v.expTotal});
    #1;
    check_outputs(name);
  endtask

  // ---------------- test ----------------
  vec_t vecs[35];

  initial begin
    //            rst h f v w rd lat s0 s1 used  fwd     stall run total
    // reset, then ALU producer r5 followed by a branch on r5
    vecs[0]  = mk(1, 0,0,0,0, 0, 0,  0, 0, 0,    0,      0, 0, 0);
    vecs[1]  = mk(0, 0,0,1,1, 5, 1,  0, 0, 0,    0,      0, 0, 0);
    vecs[2]  = mk(0, 0,0,1,0, 0, 0,  5, 0, 1,    0,      1, 0, 0);
    vecs[3]  = mk(0, 0,0,1,0, 0, 0,  5, 0, 1,    4'b0001,0, 1, 1);
    // load r7 followed by jr r7: two stalls, forward from MEM/WB, then regfile
    vecs[4]  = mk(0, 0,0,1,1, 7, 2,  0, 0, 0,    0,      0, 0, 1);
    vecs[5]  = mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    0,      1, 0, 1);
    vecs[6]  = mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    0,      1, 1, 2);
    vecs[7]  = mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    4'b0010,0, 2, 3);
    vecs[8]  = mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    0,      0, 0, 3);
    // two writers of r3: youngest wins, both sources get the same select
    vecs[9]  = mk(0, 0,0,1,1, 3, 1,  0, 0, 0,    0,      0, 0, 3);
    vecs[10] = mk(0, 0,0,1,1, 3, 1,  0, 0, 0,    0,      0, 0, 3);
    vecs[11] = mk(0, 0,0,1,0, 0, 0,  3, 3, 3,    0,      1, 0, 3);
    vecs[12] = mk(0, 0,0,1,0, 0, 0,  3, 3, 3,    4'b0101,0, 1, 4);
    // writes to r0 and reads of r0
    vecs[13] = mk(0, 0,0,1,1, 0, 1,  0, 0, 3,    0,      0, 0, 4);
    vecs[14] = mk(0, 0,0,1,0, 0, 0,  0, 0, 3,    0,      0, 0, 4);
    // unused sources never stall; source 1 alone forwards
    vecs[15] = mk(0, 0,0,1,1, 9, 1,  0, 0, 0,    0,      0, 0, 4);
    vecs[16] = mk(0, 0,0,1,0, 0, 0,  9, 9, 0,    0,      0, 0, 4);
    vecs[17] = mk(0, 0,0,1,0, 0, 0,  0, 9, 2,    4'b0100,0, 0, 4);
    vecs[18] = mk(0, 0,0,1,0, 0, 0,  0, 9, 2,    4'b1000,0, 0, 4);
    // flush with a hazard: no stall and the flushed writer of r13 is dropped
    vecs[19] = mk(0, 0,0,1,1, 12,2,  0, 0, 0,    0,      0, 0, 4);
    vecs[20] = mk(0, 0,1,1,1, 13,1, 12, 0, 1,    0,      0, 0, 4);
    vecs[21] = mk(0, 0,0,1,0, 0, 0, 13,12, 3,    0,      1, 0, 4);
    vecs[22] = mk(0, 0,0,1,0, 0, 0, 13,12, 3,    4'b1000,0, 1, 5);
    // latency 0 behaves as 1
    vecs[23] = mk(0, 0,0,1,1, 20,0,  0, 0, 0,    0,      0, 0, 5);
    vecs[24] = mk(0, 0,0,1,0, 0, 0, 20, 0, 1,    0,      1, 0, 5);
    vecs[25] = mk(0, 0,0,1,0, 0, 0, 20, 0, 1,    4'b0001,0, 1, 6);
    // latency 3 behaves as DEPTH-1 = 2
    vecs[26] = mk(0, 0,0,1,1, 21,3,  0, 0, 0,    0,      0, 0, 6);
    vecs[27] = mk(0, 0,0,1,0, 0, 0, 21, 0, 1,    0,      1, 0, 6);
    vecs[28] = mk(0, 0,0,1,0, 0, 0, 21, 0, 1,    0,      1, 1, 7);
    vecs[29] = mk(0, 0,0,1,0, 0, 0, 21, 0, 1,    4'b0010,0, 2, 8);
    // no valid instruction in ID: no stall even with a hazarded source
    vecs[30] = mk(0, 0,0,1,1, 22,1,  0, 0, 0,    0,      0, 0, 8);
    vecs[31] = mk(0, 0,0,0,0, 0, 0, 22, 0, 1,    0,      0, 0, 8);
    vecs[32] = mk(0, 0,0,1,0, 0, 0, 22, 0, 1,    4'b0001,0, 0, 8);
    vecs[33] = mk(0, 0,0,0,0, 0, 0,  0, 0, 0,    0,      0, 0, 8);
    vecs[34] = mk(0, 0,0,0,0, 0, 0,  0, 0, 0,    0,      0, 0, 8);

    for (int i = 0; i < 35; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // hold for 3 cycles during a load hazard, then 2 more stalls
    apply_vec(mk(0, 0,0,1,1, 7, 2,  0, 0, 0,    0,      0, 0, 8),  "hold_ins");
    apply_vec(mk(0, 1,0,1,0, 0, 0,  7, 0, 1,    0,      1, 0, 8),  "hold_1");
    apply_vec(mk(0, 1,0,1,0, 0, 0,  7, 0, 1,    0,      1, 1, 8),  "hold_2");
    apply_vec(mk(0, 1,0,1,0, 0, 0,  7, 0, 1,    0,      1, 2, 8),  "hold_3");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    0,      1, 3, 8),  "hold_rel1");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    0,      1, 4, 9),  "hold_rel2");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  7, 0, 1,    4'b0010,0, 5, 10), "hold_fwd");

    // flush in the middle of a stall run clears the run
    apply_vec(mk(0, 0,0,1,1, 8, 2,  0, 0, 0,    0,      0, 0, 10), "flush_ins");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  8, 0, 1,    0,      1, 0, 10), "flush_stall");
    apply_vec(mk(0, 0,1,1,0, 0, 0,  8, 0, 1,    0,      0, 1, 11), "flush_kill");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  8, 0, 1,    4'b0010,0, 0, 11), "flush_fwd");

    // reset mid-stall, asserted together with hold
    apply_vec(mk(0, 0,0,1,1, 9, 2,  0, 0, 0,    0,      0, 0, 11), "rst_ins");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  9, 0, 1,    0,      1, 0, 11), "rst_stall");
    apply_vec(mk(1, 1,0,1,0, 0, 0,  9, 0, 1,    0,      1, 1, 12), "rst_edge");
    apply_vec(mk(0, 0,0,1,0, 0, 0,  9, 0, 1,    0,      0, 0, 0),  "rst_after");

    // stall_run saturation under a long hold
    apply_vec(mk(0, 0,0,1,1, 10,2,  0, 0, 0,    0,      0, 0, 0),  "sat_ins");
    for (int k = 0; k < 260; k++) begin
      apply_vec(mk(0, 1,0,1,0, 0, 0, 10, 0, 1,  0,      1, (k > 255) ? 255 : k, 0),
                $sformatf("sat_hold%0d", k));
    end
    apply_vec(mk(0, 0,0,1,0, 0, 0, 10, 0, 1,    0,      1, 255, 0), "sat_rel1");
    apply_vec(mk(0, 0,0,1,0, 0, 0, 10, 0, 1,    0,      1, 255, 1), "sat_rel2");
    apply_vec(mk(0, 0,0,1,0, 0, 0, 10, 0, 1,    4'b0010,0, 255, 2), "sat_fwd");
    apply_vec(mk(0, 0,0,0,0, 0, 0,  0, 0, 0,    0,      0, 0, 2),   "sat_idle");

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      nFails++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
